// File: rtl/instruction_fifo_arbiter4_pkg.sv
// Shared fetch-side constants: strand count, default FIFO depth and entry width.
// Also holds the round-robin index helper used by the arbiter.
package instruction_fifo_arbiter4_pkg;

  localparam int NUM_STRANDS = 4;
  localparam int FIFO_DEPTH  = 8;
  localparam int ENTRY_WIDTH = 64;

  // Strand index 'offset' places after 'base', wrapping over the four strands.
  function automatic logic [1:0] rr_index(input logic [1:0] base, input logic [2:0] offset);
    return base + offset[1:0];
  endfunction

endpackage

// File: rtl/arbiter4.sv
// Four-way round-robin fetch arbiter; grant is combinational from requests.
// No backpressure: the pointer only moves on edges where something is granted.
module arbiter4
  import instruction_fifo_arbiter4_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] request,
  output logic [3:0] grant,
  output logic       access
);

  logic [1:0] last_grant;
  logic [1:0] grant_idx;
  logic [1:0] cand;
  logic       found;

  assign access = |request;

  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    cand      = '0;
    found     = 1'b0;
    for (int i = 1; i <= NUM_STRANDS; i++) begin
      cand = rr_index(last_grant, 3'(i));
      if (!found && request[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

  // Reset to strand 3 so strand 0 leads the first search.
  always_ff @(posedge clk) begin
    if (reset)        last_grant <= 2'd3;
    else if (found)   last_grant <= grant_idx;
  end

endmodule

// File: rtl/instruction_fifo.sv
// Per-strand show-ahead instruction FIFO; head visible combinationally, no added latency.
// Backpressure: full drops enqueues unless a dequeue frees a slot; request drops two entries early.
module instruction_fifo
  import instruction_fifo_arbiter4_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = ENTRY_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             enqueue,
  input  logic [WIDTH-1:0] enqueue_value,
  input  logic             dequeue,
  output logic             request,
  output logic             ready,
  output logic [WIDTH-1:0] value
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);
  localparam logic [CW-1:0] REQ_MAX_FILL = CW'(DEPTH - 2);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    count;
  logic             do_deq;
  logic             do_enq;

  assign ready   = (count != '0);
  assign do_deq  = dequeue && ready;
  assign do_enq  = enqueue && ((count < FULL_COUNT) || do_deq);
  // Two slots of headroom so a grant issued while a fetch is in flight still lands.
  assign request = (count <= REQ_MAX_FILL) && !flush;
  assign value   = mem[head];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_enq) tail <= tail + 1'b1;
      if (do_deq) head <= head + 1'b1;
      if (do_enq && !do_deq)      count <= count + 1'b1;
      else if (do_deq && !do_enq) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq && !flush && !reset) mem[tail] <= enqueue_value;
  end

endmodule

// File: rtl/instruction_fifo_arbiter4.sv
// Four strand instruction FIFOs plus round-robin fetch arbiter; all outputs combinational.
// Backpressure: a strand stops requesting fetch once its FIFO is within two entries of full.
module instruction_fifo_arbiter4
  import instruction_fifo_arbiter4_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = ENTRY_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       flush_i,
  input  logic [3:0]       enqueue_i,
  input  logic [WIDTH-1:0] enqueue_value_i,
  input  logic [3:0]       dequeue_i,
  output logic [3:0]       grant_o,
  output logic             access_o,
  output logic [3:0]       ready_o,
  output logic [WIDTH-1:0] value0_o,
  output logic [WIDTH-1:0] value1_o,
  output logic [WIDTH-1:0] value2_o,
  output logic [WIDTH-1:0] value3_o
);

  logic [3:0]       request;
  logic [WIDTH-1:0] strand_value [NUM_STRANDS];

  for (genvar n = 0; n < NUM_STRANDS; n++) begin : g_strand
    instruction_fifo #(
      .DEPTH(DEPTH),
      .WIDTH(WIDTH)
    ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush_i[n]),
      .enqueue      (enqueue_i[n]),
      .enqueue_value(enqueue_value_i),
      .dequeue      (dequeue_i[n]),
      .request      (request[n]),
      .ready        (ready_o[n]),
      .value        (strand_value[n])
    );
  end

  arbiter4 u_arbiter (
    .clk    (clk),
    .reset  (reset),
    .request(request),
    .grant  (grant_o),
    .access (access_o)
  );

  assign value0_o = strand_value[0];
  assign value1_o = strand_value[1];
  assign value2_o = strand_value[2];
  assign value3_o = strand_value[3];

endmodule

// File: tb/tb_instruction_fifo_arbiter4.sv
// Scenario tasks plus randomized traffic against a queue-based model of the four strands.
module tb_instruction_fifo_arbiter4;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  flush_i, enqueue_i, dequeue_i;
  logic [63:0] enqueue_value_i;
  logic [3:0]  grant_o, ready_o;
  logic        access_o;
  logic [63:0] value0_o, value1_o, value2_o, value3_o;
  logic [63:0] dut_val [4];

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] mq [4][$];
  int          m_last = 3;

  instruction_fifo_arbiter4 #(.DEPTH(DEPTH), .WIDTH(64)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .enqueue_i(enqueue_i),
    .enqueue_value_i(enqueue_value_i), .dequeue_i(dequeue_i), .grant_o(grant_o),
    .access_o(access_o), .ready_o(ready_o), .value0_o(value0_o), .value1_o(value1_o),
    .value2_o(value2_o), .value3_o(value3_o)
  );

  assign dut_val[0] = value0_o;
  assign dut_val[1] = value1_o;
  assign dut_val[2] = value2_o;
  assign dut_val[3] = value3_o;

  always #5 clk = ~clk;

  function automatic logic [3:0] m_request();
    logic [3:0] r;
    for (int n = 0; n < 4; n++) r[n] = (mq[n].size() <= DEPTH - 2) && !flush_i[n];
    return r;
  endfunction

  function automatic logic [3:0] m_grant();
    logic [3:0] r = m_request();
    logic [3:0] g = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      int s = (m_last + k) % 4;
      if (g == 4'b0000 && r[s]) g[s] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic [3:0] m_ready();
    logic [3:0] r;
    for (int n = 0; n < 4; n++) r[n] = (mq[n].size() != 0);
    return r;
  endfunction

  task automatic model_step();
    logic [3:0] g = m_grant();
    if (reset) begin
      for (int n = 0; n < 4; n++) mq[n].delete();
      m_last = 3;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (flush_i[n]) mq[n].delete();
        else begin
          bit d = dequeue_i[n] && (mq[n].size() > 0);
          bit e = enqueue_i[n] && ((mq[n].size() < DEPTH) || d);
          if (d) void'(mq[n].pop_front());
          if (e) mq[n].push_back(enqueue_value_i);
        end
      end
      for (int n = 0; n < 4; n++) if (g[n]) m_last = n;
    end
  endtask

  task automatic clear_in();
    reset = 1'b0; flush_i = '0; enqueue_i = '0; dequeue_i = '0;
    enqueue_value_i = {$urandom, $urandom};
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic test_reset();
    clear_in();
    reset = 1'b1; enqueue_i = 4'b0100; dequeue_i = 4'b1111; flush_i = 4'b0001;
    tick();
    #1;
    vectors++; if (ready_o !== 4'b0000) begin miscompares++; $display("FAIL reset_ready: got %b expected 0000", ready_o); end
    vectors++; if (grant_o !== 4'b0001) begin miscompares++; $display("FAIL reset_grant: got %b expected 0001", grant_o); end
    vectors++; if (access_o !== 1'b1) begin miscompares++; $display("FAIL reset_access: got %b expected 1", access_o); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (grant_o !== exp_seq[i]) begin miscompares++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, grant_o, exp_seq[i]); end
      tick();
    end
  endtask

  task automatic test_enqueue();
    enqueue_i = 4'b0100; enqueue_value_i = 64'h00000010_AABBCCDD;
    tick();
    #1;
    vectors++; if (ready_o !== 4'b0100) begin miscompares++; $display("FAIL enq_ready: got %b expected 0100", ready_o); end
    vectors++; if (value2_o !== 64'h00000010_AABBCCDD) begin miscompares++; $display("FAIL enq_value2: got %h expected 00000010aabbccdd", value2_o); end
    dequeue_i = 4'b0100;
    tick();
    #1;
    vectors++; if (ready_o !== 4'b0000) begin miscompares++; $display("FAIL deq_ready: got %b expected 0000", ready_o); end
  endtask

  task automatic test_fill();
    logic [63:0] vals [9];
    for (int i = 0; i < 7; i++) begin
      enqueue_i = 4'b0001; vals[i] = enqueue_value_i;
      tick();
    end
    #1;
    vectors++; if (grant_o[0] !== 1'b0) begin miscompares++; $display("FAIL fill_skip0: got %b expected bit0 clear", grant_o); end
    vectors++; if (grant_o !== m_grant()) begin miscompares++; $display("FAIL fill_grant: got %b expected %b", grant_o, m_grant()); end
    vectors++; if (access_o !== 1'b1) begin miscompares++; $display("FAIL fill_access: got %b expected 1", access_o); end
    for (int i = 7; i < 9; i++) begin
      enqueue_i = 4'b0001; vals[i] = enqueue_value_i;
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      #1;
      vectors++; if (ready_o[0] !== 1'b1 || value0_o !== vals[i]) begin
        miscompares++; $display("FAIL fill_drain[%0d]: got %b/%h expected 1/%h", i, ready_o[0], value0_o, vals[i]);
      end
      dequeue_i = 4'b0001;
      tick();
    end
    #1;
    vectors++; if (ready_o[0] !== 1'b0) begin miscompares++; $display("FAIL fill_ninth_dropped: got ready0=%b expected 0", ready_o[0]); end
  endtask

  task automatic test_flush();
    logic [63:0] nv;
    for (int i = 0; i < 3; i++) begin enqueue_i = 4'b0010; tick(); end
    flush_i = 4'b0010; enqueue_i = 4'b0010;
    tick();
    #1;
    vectors++; if (ready_o[1] !== 1'b0) begin miscompares++; $display("FAIL flush_ready1: got %b expected 0", ready_o[1]); end
    enqueue_i = 4'b0010; nv = enqueue_value_i;
    tick();
    #1;
    vectors++; if (ready_o[1] !== 1'b1 || value1_o !== nv) begin miscompares++; $display("FAIL flush_newval: got %b/%h expected 1/%h", ready_o[1], value1_o, nv); end
    dequeue_i = 4'b0010;
    tick();
    #1;
    vectors++; if (ready_o[1] !== 1'b0) begin miscompares++; $display("FAIL flush_onlyone: got %b expected 0", ready_o[1]); end
  endtask

  task automatic test_full_simul();
    logic [63:0] vals [9];
    for (int i = 0; i < 8; i++) begin enqueue_i = 4'b1000; vals[i] = enqueue_value_i; tick(); end
    enqueue_i = 4'b1000; dequeue_i = 4'b1000; vals[8] = enqueue_value_i;
    tick();
    for (int i = 1; i < 9; i++) begin
      #1;
      vectors++; if (ready_o[3] !== 1'b1 || value3_o !== vals[i]) begin
        miscompares++; $display("FAIL full_simul[%0d]: got %b/%h expected 1/%h", i, ready_o[3], value3_o, vals[i]);
      end
      dequeue_i = 4'b1000;
      tick();
    end
    #1;
    vectors++; if (ready_o[3] !== 1'b0) begin miscompares++; $display("FAIL full_simul_count: got %b expected 0", ready_o[3]); end
  endtask

  task automatic test_alternate();
    logic [3:0] prev = 4'b0000;
    for (int i = 0; i < 7; i++) begin enqueue_i = 4'b0001; tick(); enqueue_i = 4'b0100; tick(); end
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (grant_o !== m_grant() || grant_o === prev || !(grant_o === 4'b0010 || grant_o === 4'b1000)) begin
        miscompares++; $display("FAIL alt_grant[%0d]: got %b expected %b", i, grant_o, m_grant());
      end
      prev = grant_o;
      tick();
    end
    reset = 1'b1;
    tick();
    #1;
    vectors++; if (grant_o !== 4'b0001) begin miscompares++; $display("FAIL alt_after_reset: got %b expected 0001", grant_o); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      flush_i   = ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      enqueue_i = ($urandom_range(0, 3) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      dequeue_i = 4'($urandom_range(0, 15));
      #1;
      vectors++; if (grant_o !== m_grant()) begin miscompares++; $display("FAIL rnd_grant@%0d: got %b expected %b", c, grant_o, m_grant()); end
      vectors++; if (access_o !== (|m_request())) begin miscompares++; $display("FAIL rnd_access@%0d: got %b expected %b", c, access_o, |m_request()); end
      vectors++; if (ready_o !== m_ready()) begin miscompares++; $display("FAIL rnd_ready@%0d: got %b expected %b", c, ready_o, m_ready()); end
      for (int n = 0; n < 4; n++) begin
        if (mq[n].size() > 0) begin
          vectors++; if (dut_val[n] !== mq[n][0]) begin miscompares++; $display("FAIL rnd_value%0d@%0d: got %h expected %h", n, c, dut_val[n], mq[n][0]); end
        end
      end
      tick();
    end
  endtask

  initial begin
    clear_in();
    @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_enqueue();
    test_fill();
    test_flush();
    test_full_simul();
    test_alternate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
